// File: rtl/mux_arb_pkg.sv
// Shared types and the round-robin search used by the mux4x1 arbiter.
// The pick function is kept here so the top stays a plain state/next-state pair.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First requesting index at or after start (mod 4), optionally skipping one index.
  // Walking from the far end backwards lets the closest candidate win last.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [SEL_W-1:0]   start,
                                    input logic               exclude_en,
                                    input logic [SEL_W-1:0]   exclude_idx);
    pick_t            res;
    logic [SEL_W-1:0] idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = start + SEL_W'(k);
      if (req[idx] && !(exclude_en && (idx == exclude_idx))) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux4x1.sv
// Four-to-one single-bit multiplexer shared by the arbiter's requesters.
module mux4x1 (
  input  logic [3:0] ip,
  input  logic [1:0] sel,
  output logic       out
);

  assign out = ip[sel];

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter granting one of four requesters the shared mux4x1 path,
// with a per-grant hold budget that only bites when someone else is waiting.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] ip,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] gnt,
  output logic               valid,
  output logic               out
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  arb_state_t         state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               valid_q, valid_d;
  logic [3:0]         hold_cnt_q, hold_cnt_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;

  pick_t              pick_any;
  pick_t              pick_other;
  logic               grant_en;
  logic [SEL_W-1:0]   grant_idx;
  logic               mux_out;

  assign pick_any   = rr_pick(req, ptr_q, 1'b0, '0);
  assign pick_other = rr_pick(req, ptr_q, 1'b1, sel_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      gnt_q      <= '0;
      valid_q    <= 1'b0;
      hold_cnt_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      valid_q    <= valid_d;
      hold_cnt_q <= hold_cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  // Decide whether a new owner is chosen this edge; the grant itself is applied once below.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    valid_d    = valid_q;
    hold_cnt_d = hold_cnt_q;
    ptr_d      = ptr_q;
    grant_en   = 1'b0;
    grant_idx  = '0;

    unique case (state_q)
      IDLE: begin
        gnt_d   = '0;
        valid_d = 1'b0;
        if (pick_any.found) begin
          grant_en  = 1'b1;
          grant_idx = pick_any.idx;
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          if (pick_any.found) begin
            grant_en  = 1'b1;
            grant_idx = pick_any.idx;
          end else begin
            state_d    = IDLE;
            gnt_d      = '0;
            valid_d    = 1'b0;
            hold_cnt_d = '0;
          end
        end else if (hold_cnt_q < HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end else if (pick_other.found) begin
          grant_en  = 1'b1;
          grant_idx = pick_other.idx;
        end else begin
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase

    if (grant_en) begin
      state_d    = GRANT;
      sel_d      = grant_idx;
      gnt_d      = NUM_REQ'(1) << grant_idx;
      valid_d    = 1'b1;
      hold_cnt_d = '0;
      ptr_d      = grant_idx + SEL_W'(1);
    end
  end

  mux4x1 u_mux (
    .ip (ip),
    .sel(sel_q),
    .out(mux_out)
  );

  assign sel   = sel_q;
  assign gnt   = gnt_q;
  assign valid = valid_q;
  assign out   = mux_out & valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: a queue-and-index reference model predicts
// each edge's grant, and independent monitors compare on both clock phases.
module tb_mux_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] ip;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       valid;
  logic       out;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
  } exp_t;

  exp_t expQ[$];
  exp_t curExp;
  bit   haveCur;
  int   testsRun;
  int   testsFailed;

  // Reference model: owner index (-1 when idle), cycles held, search start, last select.
  int   mOwner;
  int   mHold;
  int   mPtr;
  int   mSel;

  mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .ip   (ip),
    .sel  (sel),
    .gnt  (gnt),
    .valid(valid),
    .out  (out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int firstFrom(input logic [3:0] r, input int start, input int skip);
    int i;
    for (int k = 0; k < 4; k++) begin
      i = (start + k) % 4;
      if (r[i] && i != skip) return i;
    end
    return -1;
  endfunction

  task automatic take(input int c);
    mOwner = c;
    mSel   = c;
    mHold  = 0;
    mPtr   = (c + 1) % 4;
  endtask

  task automatic modelStep(input logic aRst, input logic [3:0] r);
    int c;
    if (aRst) begin
      mOwner = -1;
      mHold  = 0;
      mPtr   = 0;
      mSel   = 0;
    end else if (mOwner < 0) begin
      c = firstFrom(r, mPtr, -1);
      if (c >= 0) take(c);
    end else if (!r[mOwner]) begin
      c = firstFrom(r, mPtr, -1);
      if (c >= 0) take(c);
      else mOwner = -1;
    end else if (mHold < MAX_HOLD - 1) begin
      mHold++;
    end else begin
      c = firstFrom(r, mPtr, mOwner);
      if (c >= 0) take(c);
      else mHold = 0;
    end
  endtask

  task automatic applyStimulus(input logic aRst, input logic [3:0] aReq, input logic [3:0] aIp);
    exp_t e;
    @(negedge clk);
    rst = aRst;
    req = aReq;
    ip  = aIp;
    modelStep(aRst, aReq);
    e.gnt   = (mOwner < 0) ? 4'b0000 : 4'(1 << mOwner);
    e.sel   = 2'(mSel);
    e.valid = (mOwner >= 0);
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] want);
    testsRun++;
    if (act !== want) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, want);
    end
  endtask

  function automatic logic expOut();
    return curExp.valid ? ip[curExp.sel] : 1'b0;
  endfunction

  // Registered outputs are compared just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        curExp  = expQ.pop_front();
        haveCur = 1'b1;
        checkOutput("gnt", gnt, curExp.gnt);
        checkOutput("sel", {2'b00, sel}, {2'b00, curExp.sel});
        checkOutput("valid", {3'b000, valid}, {3'b000, curExp.valid});
        checkOutput("out", {3'b000, out}, {3'b000, expOut()});
      end
    end
  end

  // Data changed mid-cycle must reach out without waiting for an edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (haveCur) checkOutput("outPassthru", {3'b000, out}, {3'b000, expOut()});
    end
  end

  initial begin
    logic [3:0] rq;
    logic       rr;
    testsRun    = 0;
    testsFailed = 0;
    haveCur     = 1'b0;
    rst         = 1'b1;
    req         = 4'b0000;
    ip          = 4'b0000;
    mOwner      = -1;
    mHold       = 0;
    mPtr        = 0;
    mSel        = 0;

    repeat (2) applyStimulus(1'b1, 4'b1111, 4'b1111);
    repeat (17) applyStimulus(1'b0, 4'b1111, 4'($urandom));

    repeat (2) applyStimulus(1'b0, 4'b0000, 4'b1111);
    applyStimulus(1'b0, 4'b0010, 4'b0010);
    applyStimulus(1'b0, 4'b0010, 4'b0000);
    applyStimulus(1'b0, 4'b0000, 4'b0000);

    repeat (10) applyStimulus(1'b0, 4'b0100, 4'($urandom));

    repeat (2) applyStimulus(1'b0, 4'b1000, 4'b1001);
    repeat (2) applyStimulus(1'b0, 4'b1001, 4'b1001);
    applyStimulus(1'b0, 4'b0001, 4'b0001);
    repeat (2) applyStimulus(1'b0, 4'b0000, 4'b0001);

    repeat (2) applyStimulus(1'b0, 4'b0100, 4'b0100);
    applyStimulus(1'b1, 4'b0100, 4'b0100);
    repeat (2) applyStimulus(1'b0, 4'b1100, 4'b1100);

    rq = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(7) == 0) rq[b] = ~rq[b];
      end
      rr = ($urandom_range(299) == 0);
      applyStimulus(rr, rq, 4'($urandom));
    end

    repeat (2) applyStimulus(1'b0, 4'b0000, 4'b0000);
    repeat (2) @(negedge clk);

    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboardDrain: got %0d pending, expected 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one mux4x1 data path among four requesters. It samples four request lines and grants exactly one requester at a time. It drives the mux select from the current grant and presents the selected data bit on `out`. Each grant lasts until the requester drops its request or its hold budget runs out while another requester is waiting.

## Interface

Parameters:
- `MAX_HOLD`, default 4: maximum consecutive grant cycles while another requester waits. Legal range 1..15.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `req`, input, 4: request lines. `req[i]` belongs to requester i.
- `ip`, input, 4: data lines. `ip[i]` is requester i's data bit.
- `sel`, output, 2: registered select driving the internal mux4x1. Holds the last granted index.
- `gnt`, output, 4: registered one-hot grant. All zero when idle.
- `valid`, output, 1: registered. High exactly when `gnt` is non-zero.
- `out`, output, 1: `ip[sel]` when `valid`=1, otherwise 0. Combinational from `ip`, `sel` and `valid`.

## Operation

- States: IDLE and GRANT. Registers: `sel`, `gnt`, `valid`, `hold_cnt` (4 bits), `ptr` (2 bits, search start).
- Pick rule: the first index i with `req[i]`=1, searching `ptr`, `ptr`+1, … mod 4. The search wraps 3→0.
- IDLE:
  - `gnt`=0 and `valid`=0.
  - If `req`≠0 at an edge, go to GRANT with `sel`=pick, `gnt`=one-hot(pick), `hold_cnt`=0, `ptr`=pick+1 mod 4.
- GRANT, evaluated at each edge with `g`=`sel`:
  - `req[g]`=0 and other requests pending: switch to the next pick. This is a zero-bubble handover.
  - `req[g]`=0 and no other requests pending: go to IDLE. `sel` holds `g`.
  - `req[g]`=1 and `hold_cnt`<`MAX_HOLD`-1: stay on `g`, `hold_cnt`+1.
  - `req[g]`=1, `hold_cnt`=`MAX_HOLD`-1, another request pending: rotate to the next pick, excluding `g`. `hold_cnt`=0.
  - `req[g]`=1, `hold_cnt`=`MAX_HOLD`-1, no other request pending: stay on `g`. `hold_cnt`=0.
- Every new grant sets `ptr`=granted index+1 mod 4.
- Arithmetic:
  - `hold_cnt` never exceeds `MAX_HOLD`-1.
  - The `ptr`/`sel` increments wrap mod 4 in 2 bits.
- Data path:
  - `ip` changes during a grant pass through to `out` in the same cycle.
  - The arbiter never registers data.

## Timing

- Reset values: `sel`=00, `gnt`=0000, `valid`=0, `out`=0, `hold_cnt`=0, `ptr`=0, state IDLE.
- Reset mid-grant: all of the above take effect at the next edge. There is no partial release.
- Request-to-grant latency: `req` high before edge N gives `gnt`/`valid` high after edge N, a 1-cycle latency.
- Release latency: `req[g]` low before edge N removes `gnt[g]` after edge N.
- Handover: the new `gnt` appears at the same edge, so `valid` stays high with no bubble.
- Simultaneous release and budget expiry: release wins. The rule is the same in both cases, so the next pick is identical.
- `gnt` is never multi-hot. `sel` and `gnt` always change on the same edge.
- Fairness: a continuously requesting port waits at most 3·`MAX_HOLD` cycles after its request is sampled.

## Structure

- Package `mux_arb_pkg`:
  - `NUM_REQ`=4, `SEL_W`=2.
  - State enum `arb_state_t` {IDLE, GRANT}.
  - Round-robin pick function `rr_pick(req, start, exclude_en, exclude_idx)`.
- Sub-module: one instance of the existing `mux4x1`, with `.ip(ip)`, `.sel(sel)`, `.out(mux_out)`.
  - `out` = `mux_out` & `valid`.
- All remaining logic is a single always block for the state and registers, plus combinational next-state logic.

## Test plan

- Reset: hold `rst`=1 for 2 cycles with `req`=1111. Required: `gnt`=0000, `sel`=00, `valid`=0, `out`=0. After release, the first grant is `gnt`=0001.
- Single request: `req`=0010, `ip`=0010. Required: after the next edge, `gnt`=0010, `sel`=01, `valid`=1, `out`=1. Then set `ip`=0000; required: `out`=0 in the same cycle.
- Full contention: `req`=1111 held, `MAX_HOLD`=4. Required: grant sequence 0→1→2→3→0, each held exactly 4 cycles, `valid` continuously 1.
- Lone long request: `req`=0100 held for 10 cycles. Required: `gnt`=0100 for all 10 cycles, with no drop at budget expiry.
- Wrap handover: requester 3 granted with `req`=1001. Drop `req[3]`. Required: next edge `gnt`=0001, `sel`=00, no bubble. Drop all requests; required: IDLE, `gnt`=0000, `sel` holds 00.
- Reset mid-grant: assert `rst` while `gnt`=0100. Required: next edge all outputs reset. Then `req`=1100; required: `gnt`=0100 because `ptr` was reset to 0.
